mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 28, meaning the memory line-block address width.
REQ-002 SHALL have parameter DATA_BITS, default 128, meaning the memory data beat width; the mask width is DATA_BITS/8.
REQ-003 SHALL have parameter RESP_BEATS, default 4, meaning the number of mem_resp_valid beats returned per read request.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have ports clk (input, 1, clock) and reset (input, 1, async active-high reset).
REQ-006 SHALL have, per requester p in {0,1}: p_req_valid (in, 1), p_req_ready (out, 1), p_req_addr (in, ADDR_BITS), p_req_rw (in, 1, 1 = write), p_req_data_valid (in, 1), p_req_data_ready (out, 1), p_req_data_bits (in, DATA_BITS), p_req_data_mask (in, DATA_BITS/8), p_resp_valid (out, 1) and p_resp_data (out, DATA_BITS).
REQ-007 SHALL have a downstream port: mem_req_valid (out, 1), mem_req_ready (in, 1), mem_req_addr (out, ADDR_BITS), mem_req_rw (out, 1), mem_req_data_valid (out, 1), mem_req_data_ready (in, 1), mem_req_data_bits (out, DATA_BITS), mem_req_data_mask (out, DATA_BITS/8), mem_resp_valid (in, 1) and mem_resp_data (in, DATA_BITS).
REQ-008 SHALL have output grant (2 bits, one-hot, 00 when idle) indicating the owning requester.

Function
REQ-009 SHALL implement an FSM with states IDLE, REQ, RESP: in IDLE, any p_req_valid causes a registered grant and a transition to REQ on the next edge, giving one cycle of arbitration latency.
REQ-010 SHALL, in REQ, drive the mem_req_* fields combinationally from the granted requester and pass through mem_req_ready and mem_req_data_ready to that requester only; the non-granted requester sees ready = 0.
REQ-011 SHALL handle a read (rw = 0) as follows: on acceptance (mem_req_valid and mem_req_ready), go to RESP, then count mem_resp_valid beats and return to IDLE on beat RESP_BEATS.
REQ-012 SHALL handle a write (rw = 1) as follows: use sticky flags req_done and data_done, each set independently on its own handshake (same-cycle acceptance is legal), deassert the corresponding valid once its flag is set, and return to IDLE when both flags are set; a write produces no RESP state.
REQ-013 SHALL route mem_resp_valid to p_resp_valid of the granted requester only, and broadcast mem_resp_data to both p_resp_data.
REQ-014 SHALL ignore mem_resp_valid in IDLE and REQ: stray beats are dropped and the beat counter does not change.
REQ-015 SHALL hold the grant until the transaction completes, with no preemption.
REQ-016 SHALL size the beat counter to ceilLog2(RESP_BEATS) bits, clear it on entry to RESP, and never let it wrap past RESP_BEATS-1.
REQ-017 SHALL permit a new arbitration in the cycle after returning to IDLE, with no back-to-back grant from the RESP or REQ completion cycle.
REQ-018 SHALL rely on requesters holding p_req_valid and all request fields stable until accepted; the arbiter registers nothing except the grant, the state, the counter and the write flags.

Reset
REQ-019 SHALL, while reset is high, asynchronously force state = IDLE, grant = 00, counter = 0, both write flags = 0, and priority pointer = requester 0.
REQ-020 SHALL hold all outputs at 0 during and after reset until a grant is made: mem_req_valid, mem_req_data_valid, both p_req_ready, both p_req_data_ready and both p_resp_valid.
REQ-021 SHALL abandon any in-flight transaction on reset mid-operation, and drop its remaining response beats per REQ-014.

Configuration
REQ-022 SHALL, with macro MEM_ARB_RR_EN defined, arbitrate round-robin: on simultaneous valid the requester not granted last wins, and the pointer updates on each grant.
REQ-023 SHALL, without MEM_ARB_RR_EN, use fixed priority: requester 0 always wins simultaneous contention, and no pointer register exists.

Verification
REQ-024 SHALL cover a single read: p0 valid with addr 0x0000040 and rw = 0 -> grant = 01 next cycle, mem_req_addr = 0x0000040, four resp beats D0..D3 appear on p0_resp_valid only, then grant = 00.
REQ-025 SHALL cover a write with split handshakes: p1 write of addr 0x1234567, data 0xA5.., mask 0xFFFF; mem_req_ready at cycle 2 and data_ready at cycle 4 -> each valid drops after its own handshake, IDLE at cycle 5, no p1_resp_valid.
REQ-026 SHALL cover contention: p0 and p1 valid together twice in succession -> with MEM_ARB_RR_EN grants are 01 then 10; without it grants are 01 then 01.
REQ-027 SHALL cover stray beats: mem_resp_valid pulsed in IDLE -> no p*_resp_valid and counter remains 0.
REQ-028 SHALL cover reset mid-read: reset asserted after 2 of 4 beats -> immediate IDLE with grant = 00, the next 2 beats are dropped, and a subsequent p1 read is served normally.
REQ-029 SHALL cover holdoff: p1 requests while p0 read is in RESP -> p1_req_ready = 0 throughout, and p1 is granted in the cycle after p0 returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single memory port.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   p0_* / p1_*                requester ports: request channel (valid/ready,
//                              addr, rw), write-data channel (valid/ready,
//                              bits, mask), response (valid, data)
//   mem_*                      downstream memory port, same channel layout
//   grant                      one-hot owning requester, 00 when idle
//
// A transaction owns the memory port from grant until completion:
//   read  : request handshake, then RESP_BEATS response beats
//   write : request and data handshakes, in either order or together
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise requester 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_BITS  = 28,
    parameter int DATA_BITS  = 128,
    parameter int RESP_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   p0_req_valid,
    output logic                   p0_req_ready,
    input  logic [ADDR_BITS-1:0]   p0_req_addr,
    input  logic                   p0_req_rw,
    input  logic                   p0_req_data_valid,
    output logic                   p0_req_data_ready,
    input  logic [DATA_BITS-1:0]   p0_req_data_bits,
    input  logic [DATA_BITS/8-1:0] p0_req_data_mask,
    output logic                   p0_resp_valid,
    output logic [DATA_BITS-1:0]   p0_resp_data,

    input  logic                   p1_req_valid,
    output logic                   p1_req_ready,
    input  logic [ADDR_BITS-1:0]   p1_req_addr,
    input  logic                   p1_req_rw,
    input  logic                   p1_req_data_valid,
    output logic                   p1_req_data_ready,
    input  logic [DATA_BITS-1:0]   p1_req_data_bits,
    input  logic [DATA_BITS/8-1:0] p1_req_data_mask,
    output logic                   p1_resp_valid,
    output logic [DATA_BITS-1:0]   p1_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data,

    output logic [1:0]             grant
);

    localparam int CNT_W = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RESP_BEATS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic             req_done;
    logic             data_done;
    logic [1:0]       pick;

    logic sel_valid, sel_rw, sel_data_valid;
    logic in_req, req_fire, data_fire, resp_beat, req_ok, data_ok;

    // Request fields follow the granted requester; outside REQ the valids
    // are gated off so the muxed fields are don't-care.
    always_comb begin
        if (grant[1]) begin
            sel_valid          = p1_req_valid;
            sel_rw             = p1_req_rw;
            sel_data_valid     = p1_req_data_valid;
            mem_req_addr       = p1_req_addr;
            mem_req_data_bits  = p1_req_data_bits;
            mem_req_data_mask  = p1_req_data_mask;
        end else begin
            sel_valid          = p0_req_valid;
            sel_rw             = p0_req_rw;
            sel_data_valid     = p0_req_data_valid;
            mem_req_addr       = p0_req_addr;
            mem_req_data_bits  = p0_req_data_bits;
            mem_req_data_mask  = p0_req_data_mask;
        end
    end

    assign in_req             = (state == REQ);
    assign mem_req_rw         = sel_rw;
    // Each valid is withdrawn once its own handshake has happened.
    assign mem_req_valid      = in_req & sel_valid & ~req_done;
    assign mem_req_data_valid = in_req & sel_rw & sel_data_valid & ~data_done;
    assign req_fire           = mem_req_valid & mem_req_ready;
    assign data_fire          = mem_req_data_valid & mem_req_data_ready;

    assign req_ok             = in_req & mem_req_ready & ~req_done;
    assign data_ok            = in_req & sel_rw & mem_req_data_ready & ~data_done;
    assign p0_req_ready       = grant[0] & req_ok;
    assign p1_req_ready       = grant[1] & req_ok;
    assign p0_req_data_ready  = grant[0] & data_ok;
    assign p1_req_data_ready  = grant[1] & data_ok;

    // Beats outside RESP are strays and never reach a requester.
    assign resp_beat          = (state == RESP) & mem_resp_valid;
    assign p0_resp_valid      = grant[0] & resp_beat;
    assign p1_resp_valid      = grant[1] & resp_beat;
    assign p0_resp_data       = mem_resp_data;
    assign p1_resp_data       = mem_resp_data;

`ifdef MEM_ARB_RR_EN
    // rr_ptr names the requester that wins the next tie.
    logic rr_ptr;

    always_comb begin
        if (p0_req_valid & p1_req_valid) pick = rr_ptr ? 2'b10 : 2'b01;
        else if (p0_req_valid)           pick = 2'b01;
        else if (p1_req_valid)           pick = 2'b10;
        else                             pick = 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              rr_ptr <= 1'b0;
        else if (state == IDLE && pick != 2'b00) rr_ptr <= pick[0];
    end
`else
    always_comb begin
        if (p0_req_valid)      pick = 2'b01;
        else if (p1_req_valid) pick = 2'b10;
        else                   pick = 2'b00;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 2'b00;
            beat_cnt  <= '0;
            req_done  <= 1'b0;
            data_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick != 2'b00) begin
                        grant <= pick;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (sel_rw) begin
                        if ((req_done | req_fire) & (data_done | data_fire)) begin
                            state     <= IDLE;
                            grant     <= 2'b00;
                            req_done  <= 1'b0;
                            data_done <= 1'b0;
                        end else begin
                            req_done  <= req_done | req_fire;
                            data_done <= data_done | data_fire;
                        end
                    end else if (req_fire) begin
                        state    <= RESP;
                        beat_cnt <= '0;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= IDLE;
                            grant    <= 2'b00;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule
